// File: rtl/eth_rx_fcs_check_if.sv
// Byte-stream interface for the receive FCS checker.
// The master side drives the post-SFD input stream and the slave side drives the checked output and status.
interface eth_rx_fcs_check_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_eop;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_eop;
   logic        out_crc_ok;
   logic        out_len_err;
   logic [10:0] out_len;

   modport master (
      output in_data, in_valid, in_eop,
      input  out_data, out_valid, out_eop, out_crc_ok, out_len_err, out_len
   );

   modport slave (
      input  in_data, in_valid, in_eop,
      output out_data, out_valid, out_eop, out_crc_ok, out_len_err, out_len
   );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Receive frame checker: strips the 4-byte FCS through a delay line and verifies CRC-32 and frame length.
// It emits payload bytes and then one end-of-frame status cycle.
module eth_rx_fcs_check #(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic              clk50,
   input  logic              rst,
   eth_rx_fcs_check_if.slave bus
);

   localparam logic [31:0] POLY    = 32'hEDB8_8320;
   localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

   typedef enum logic {IDLE, RUN} state_e;

   state_e      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] cnt_q, cnt_d;
   logic [2:0]  fill_q, fill_d;
   logic [7:0]  line_q [4];
   logic [7:0]  line_d [4];

   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_eop_q, out_eop_d;
   logic        out_crc_ok_q, out_crc_ok_d;
   logic        out_len_err_q, out_len_err_d;
   logic [10:0] out_len_q, out_len_d;

   logic [31:0] crc_v;
   logic [10:0] cnt_v;
   logic [2:0]  fill_v;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         crc_q         <= '1;
         cnt_q         <= '0;
         fill_q        <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            line_q[i] <= '0;
         end
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_eop_q     <= 1'b0;
         out_crc_ok_q  <= 1'b0;
         out_len_err_q <= 1'b0;
         out_len_q     <= '0;
      end else begin
         state_q       <= state_d;
         crc_q         <= crc_d;
         cnt_q         <= cnt_d;
         fill_q        <= fill_d;
         line_q        <= line_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_eop_q     <= out_eop_d;
         out_crc_ok_q  <= out_crc_ok_d;
         out_len_err_q <= out_len_err_d;
         out_len_q     <= out_len_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      out_data_d    = out_data_q;
      out_valid_d   = 1'b0;
      out_eop_d     = 1'b0;
      out_crc_ok_d  = out_crc_ok_q;
      out_len_err_d = out_len_err_q;
      out_len_d     = out_len_q;

      // In IDLE the working values start fresh, so a byte arriving now is folded into a clean frame.
      crc_v  = (state_q == IDLE) ? '1   : crc_q;
      cnt_v  = (state_q == IDLE) ? '0   : cnt_q;
      fill_v = (state_q == IDLE) ? 3'd0 : fill_q;

      if (bus.in_valid) begin
         crc_v   = crc_byte(crc_v, bus.in_data);
         state_d = RUN;
         if (cnt_v != '1) begin
            cnt_v = cnt_v + 11'd1;
         end
         if (fill_v == 3'd4) begin
            out_data_d  = line_q[0];
            out_valid_d = 1'b1;
         end else begin
            fill_v = fill_v + 3'd1;
         end
         // The line always shifts, so after four bytes the oldest sits in slot 0.
         for (int unsigned i = 0; i < 3; i++) begin
            line_d[i] = line_q[i+1];
         end
         line_d[3] = bus.in_data;
      end

      crc_d  = crc_v;
      cnt_d  = cnt_v;
      fill_d = fill_v;

      if (bus.in_eop) begin
         state_d       = IDLE;
         out_eop_d     = 1'b1;
         out_len_d     = cnt_v;
         out_crc_ok_d  = (cnt_v != '0) && (crc_v == RESIDUE);
         out_len_err_d = (cnt_v < MIN_L) || (cnt_v > MAX_L);
      end
   end

   assign bus.out_data    = out_data_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_eop     = out_eop_q;
   assign bus.out_crc_ok  = out_crc_ok_q;
   assign bus.out_len_err = out_len_err_q;
   assign bus.out_len     = out_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: expected payload bytes and status are queued when frames are driven.
// A monitor collects what the DUT emits for each scenario task to compare.
module tb_eth_rx_fcs_check;

   typedef struct {
      logic [10:0] len;
      logic        ok;
      logic        err;
      logic        wb;
      int unsigned cyc;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [7:0] frm [$];
   logic [7:0] exp_b [$];
   logic [7:0] obs_b [$];
   st_t        exp_s [$];
   st_t        obs_s [$];

   eth_rx_fcs_check_if bus ();

   eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
      .clk50 (clk),
      .rst   (rst),
      .bus   (bus)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid) obs_b.push_back(bus.out_data);
         if (bus.out_eop) obs_s.push_back('{bus.out_len, bus.out_crc_ok, bus.out_len_err, bus.out_valid, cyc});
      end
   end

   // Reference reflected CRC-32; FCS is its complement sent LSB first.
   function automatic logic [31:0] model_crc();
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int i = 0; i < frm.size(); i++) begin
         c = c ^ {24'd0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic append_fcs();
      logic [31:0] f;
      f = ~model_crc();
      for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic eop, input int unsigned gap);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      bus.in_eop   = eop;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_eop   = 1'b0;
      for (int g = 1; g < gap; g++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input int unsigned gap, input bit coinc,
                             input logic [10:0] elen, input logic eok, input logic eerr);
      int n = frm.size();
      for (int i = 0; i + 4 < n; i++) exp_b.push_back(frm[i]);
      for (int i = 0; i < n; i++) begin
         if (coinc && i == n - 1) exp_s.push_back('{elen, eok, eerr, (n >= 5), cyc + 1});
         drive_byte(frm[i], coinc && (i == n - 1), gap);
      end
      if (!coinc) begin
         exp_s.push_back('{elen, eok, eerr, 1'b0, cyc + 1});
         bus.in_eop = 1'b1;
         @(posedge clk); #1;
         bus.in_eop = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && (obs_b.size() < exp_b.size() || obs_s.size() < exp_s.size()); i++)
         @(posedge clk);
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic build_check_frame(input logic [7:0] first_fcs);
      frm.delete();
      for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
      frm.push_back(first_fcs);
      frm.push_back(8'h39);
      frm.push_back(8'hF4);
      frm.push_back(8'hCB);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_eop = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_eop !== 1'b0) begin n_bad++; $display("FAIL reset_eop: got %b want 0", bus.out_eop); end
      n_cmp++; if (bus.out_crc_ok !== 1'b0) begin n_bad++; $display("FAIL reset_crc_ok: got %b want 0", bus.out_crc_ok); end
      n_cmp++; if (bus.out_len_err !== 1'b0) begin n_bad++; $display("FAIL reset_len_err: got %b want 0", bus.out_len_err); end
      n_cmp++; if (bus.out_len !== 11'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", bus.out_len); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_check_string();
      build_check_frame(8'h26);
      send_frame(4, 1'b0, 11'd13, 1'b1, 1'b1);
      wait_drain();
      n_cmp++; if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL check_nbytes: got %0d want %0d", obs_b.size(), exp_b.size()); end
      n_cmp++; if (obs_s.size() != exp_s.size()) begin n_bad++; $display("FAIL check_nstatus: got %0d want %0d", obs_s.size(), exp_s.size()); end
      while (obs_b.size() > 0 && exp_b.size() > 0) begin
         logic [7:0] o = obs_b.pop_front(), e = exp_b.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL check_byte: got %h want %h", o, e); end
      end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.wb !== e.wb || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL check_status: got len=%0d ok=%b err=%b wb=%b cyc=%0d want len=%0d ok=%b err=%b wb=%b cyc=%0d",
                     o.len, o.ok, o.err, o.wb, o.cyc, e.len, e.ok, e.err, e.wb, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   task automatic test_bad_fcs();
      build_check_frame(8'h27);
      send_frame(4, 1'b0, 11'd13, 1'b0, 1'b1);
      wait_drain();
      n_cmp++; if (obs_b.size() != 9) begin n_bad++; $display("FAIL badfcs_nbytes: got %0d want 9", obs_b.size()); end
      while (obs_b.size() > 0 && exp_b.size() > 0) begin
         logic [7:0] o = obs_b.pop_front(), e = exp_b.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL badfcs_byte: got %h want %h", o, e); end
      end
      n_cmp++; if (obs_s.size() != 1) begin n_bad++; $display("FAIL badfcs_nstatus: got %0d want 1", obs_s.size()); end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL badfcs_status: got len=%0d ok=%b err=%b cyc=%0d want len=%0d ok=%b err=%b cyc=%0d",
                     o.len, o.ok, o.err, o.cyc, e.len, e.ok, e.err, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   // Frames of a given payload size with correct FCS, checked for byte count and status.
   task automatic test_length(input string name, input int payload, input logic [10:0] elen, input logic eerr);
      frm.delete();
      for (int i = 0; i < payload; i++) frm.push_back((payload == 60) ? 8'h00 : 8'($urandom_range(0, 255)));
      append_fcs();
      send_frame(1, 1'b0, elen, 1'b1, eerr);
      wait_drain();
      n_cmp++; if (obs_b.size() != payload) begin n_bad++; $display("FAIL %s_nbytes: got %0d want %0d", name, obs_b.size(), payload); end
      while (obs_b.size() > 0 && exp_b.size() > 0) begin
         logic [7:0] o = obs_b.pop_front(), e = exp_b.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL %s_byte: got %h want %h", name, o, e); end
      end
      n_cmp++; if (obs_s.size() != 1) begin n_bad++; $display("FAIL %s_nstatus: got %0d want 1", name, obs_s.size()); end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s_status: got len=%0d ok=%b err=%b cyc=%0d want len=%0d ok=%b err=%b cyc=%0d",
                     name, o.len, o.ok, o.err, o.cyc, e.len, e.ok, e.err, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   task automatic test_short_and_bare();
      frm.delete();
      frm.push_back(8'h5A);
      send_frame(1, 1'b0, 11'd1, 1'b0, 1'b1);
      exp_s.push_back('{11'd0, 1'b0, 1'b1, 1'b0, cyc + 1});
      bus.in_eop = 1'b1;
      @(posedge clk); #1;
      bus.in_eop = 1'b0;
      wait_drain();
      n_cmp++; if (obs_b.size() != 0) begin n_bad++; $display("FAIL short_nbytes: got %0d want 0", obs_b.size()); end
      n_cmp++; if (obs_s.size() != 2) begin n_bad++; $display("FAIL short_nstatus: got %0d want 2", obs_s.size()); end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.wb !== e.wb || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL short_status: got len=%0d ok=%b err=%b wb=%b cyc=%0d want len=%0d ok=%b err=%b wb=%b cyc=%0d",
                     o.len, o.ok, o.err, o.wb, o.cyc, e.len, e.ok, e.err, e.wb, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   task automatic test_back_to_back();
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(8'hA0 + 8'(i));
      append_fcs();
      send_frame(1, 1'b1, 11'd14, 1'b1, 1'b1);
      frm.delete();
      for (int i = 0; i < 12; i++) frm.push_back(8'hC0 + 8'(i));
      append_fcs();
      send_frame(1, 1'b1, 11'd16, 1'b1, 1'b1);
      wait_drain();
      n_cmp++; if (obs_b.size() != 22) begin n_bad++; $display("FAIL b2b_nbytes: got %0d want 22", obs_b.size()); end
      while (obs_b.size() > 0 && exp_b.size() > 0) begin
         logic [7:0] o = obs_b.pop_front(), e = exp_b.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_byte: got %h want %h", o, e); end
      end
      n_cmp++; if (obs_s.size() != 2) begin n_bad++; $display("FAIL b2b_nstatus: got %0d want 2", obs_s.size()); end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.wb !== e.wb || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL b2b_status: got len=%0d ok=%b err=%b wb=%b cyc=%0d want len=%0d ok=%b err=%b wb=%b cyc=%0d",
                     o.len, o.ok, o.err, o.wb, o.cyc, e.len, e.ok, e.err, e.wb, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   task automatic test_reset_mid_frame();
      frm.delete();
      for (int i = 0; i < 20; i++) frm.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 16; i++) exp_b.push_back(frm[i]);
      for (int i = 0; i < 20; i++) drive_byte(frm[i], 1'b0, 1);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #5;
      rst = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_eop !== 1'b0) begin
         n_bad++; $display("FAIL midrst_outputs: got valid=%b eop=%b want 0 0", bus.out_valid, bus.out_eop);
      end
      @(posedge clk); #1;
      build_check_frame(8'h26);
      send_frame(1, 1'b0, 11'd13, 1'b1, 1'b1);
      wait_drain();
      n_cmp++; if (obs_b.size() != 25) begin n_bad++; $display("FAIL midrst_nbytes: got %0d want 25", obs_b.size()); end
      while (obs_b.size() > 0 && exp_b.size() > 0) begin
         logic [7:0] o = obs_b.pop_front(), e = exp_b.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midrst_byte: got %h want %h", o, e); end
      end
      n_cmp++; if (obs_s.size() != 1) begin n_bad++; $display("FAIL midrst_nstatus: got %0d want 1", obs_s.size()); end
      while (obs_s.size() > 0 && exp_s.size() > 0) begin
         st_t o = obs_s.pop_front(), e = exp_s.pop_front();
         n_cmp++;
         if (o.len !== e.len || o.ok !== e.ok || o.err !== e.err || o.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL midrst_status: got len=%0d ok=%b err=%b cyc=%0d want len=%0d ok=%b err=%b cyc=%0d",
                     o.len, o.ok, o.err, o.cyc, e.len, e.ok, e.err, e.cyc);
         end
      end
      exp_b.delete(); obs_b.delete(); exp_s.delete(); obs_s.delete();
   endtask

   initial begin
      test_reset();
      test_check_string();
      test_bad_fcs();
      test_length("min", 60, 11'd64, 1'b0);
      test_length("long", 1596, 11'd1600, 1'b1);
      test_length("sat", 2100, 11'd2047, 1'b1);
      test_short_and_bare();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
